// File: rtl/sonar_uc.sv
// sonar_uc: sequencer for sonar_fd (servo sweep, HC-SR04 measurement, 8-char serial frame).
// Define SONAR_UC_TIMEOUT_EN to compile in the echo watchdog and the FALHA state.
module sonar_uc #(
   parameter int unsigned TIMEOUT_CICLOS = 2_500_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       fim_distancia,
   input  logic       fim_transmissao,
   input  logic       fim_contador_serial,
   input  logic       fim_contador_intervalo,
   output logic       zera,
   output logic       zera_pwm,
   output logic       reset_updown,
   output logic       conta_intervalo,
   output logic       medir,
   output logic       transmitir,
   output logic       conta_serial,
   output logic       conta_updown,
   output logic       pronto,
   output logic       erro,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL        = 4'h0,
      PREPARACAO     = 4'h1,
      ESPERA         = 4'h2,
      MEDIR          = 4'h3,
      AGUARDA_MEDIDA = 4'h4,
      TRANSMITE      = 4'h5,
      AGUARDA_TX     = 4'h6,
      PROX_CARACTERE = 4'h7,
      MOVE           = 4'h8,
      FALHA          = 4'hE
   } estado_t;

   estado_t estado;
   estado_t estado_prox;
   logic    timeout_c;

`ifdef SONAR_UC_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CICLOS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CICLOS);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CICLOS - 1);

   logic [CNT_W-1:0] cnt_timeout;

   // Watchdog: cleared when a measurement starts, saturating count while waiting for the echo
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_timeout <= '0;
      end else if (estado == MEDIR) begin
         cnt_timeout <= '0;
      end else if ((estado == AGUARDA_MEDIDA) && (cnt_timeout != CNT_MAX)) begin
         cnt_timeout <= cnt_timeout + CNT_W'(1);
      end
   end

   assign timeout_c = (estado == AGUARDA_MEDIDA) && (cnt_timeout == CNT_LIM);
`else
   assign timeout_c = 1'b0;
`endif

   // Next-state logic; unused codes fall back to INICIAL
   always_comb begin
      estado_prox = INICIAL;
      case (estado)
         INICIAL:        estado_prox = ligar ? PREPARACAO : INICIAL;
         PREPARACAO:     estado_prox = ESPERA;
         ESPERA: begin
            if (!ligar)                      estado_prox = INICIAL;
            else if (fim_contador_intervalo) estado_prox = MEDIR;
            else                             estado_prox = ESPERA;
         end
         MEDIR:          estado_prox = AGUARDA_MEDIDA;
         AGUARDA_MEDIDA: begin
            if (fim_distancia)  estado_prox = TRANSMITE;
            else if (timeout_c) estado_prox = FALHA;
            else                estado_prox = AGUARDA_MEDIDA;
         end
         TRANSMITE:      estado_prox = AGUARDA_TX;
         AGUARDA_TX:     estado_prox = fim_transmissao ? PROX_CARACTERE : AGUARDA_TX;
         PROX_CARACTERE: estado_prox = fim_contador_serial ? MOVE : TRANSMITE;
         MOVE:           estado_prox = ESPERA;
`ifdef SONAR_UC_TIMEOUT_EN
         FALHA:          estado_prox = MOVE;
`endif
         default:        estado_prox = INICIAL;
      endcase
   end

   // State register; outputs are decoded from the next state so they register alongside it
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado          <= INICIAL;
         zera            <= 1'b0;
         zera_pwm        <= 1'b0;
         reset_updown    <= 1'b0;
         conta_intervalo <= 1'b0;
         medir           <= 1'b0;
         transmitir      <= 1'b0;
         conta_serial    <= 1'b0;
         conta_updown    <= 1'b0;
         pronto          <= 1'b0;
      end else begin
         estado          <= estado_prox;
         zera            <= (estado_prox == PREPARACAO);
         zera_pwm        <= (estado_prox == PREPARACAO);
         reset_updown    <= (estado_prox == PREPARACAO);
         conta_intervalo <= (estado_prox == ESPERA);
         medir           <= (estado_prox == MEDIR);
         transmitir      <= (estado_prox == TRANSMITE);
         conta_serial    <= (estado_prox == PROX_CARACTERE);
         conta_updown    <= (estado_prox == MOVE);
         pronto          <= (estado_prox == MOVE);
      end
   end

`ifdef SONAR_UC_TIMEOUT_EN
   // Sticky timeout flag, cleared only when a new sweep is prepared
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         erro <= 1'b0;
      end else if (estado_prox == FALHA) begin
         erro <= 1'b1;
      end else if (estado_prox == PREPARACAO) begin
         erro <= 1'b0;
      end
   end
`else
   assign erro = 1'b0;
`endif

   assign db_estado = estado;

endmodule

// File: doc/sonar_uc.md
# sonar_uc

Control unit for the sonar datapath `sonar_fd`, sitting directly upstream of it. It sequences the servo sweep, the HC-SR04 measurement, and the 8-character serial frame. The frame is angle[3], `,`, distance[3], `#`. The block drives every control input of `sonar_fd` and consumes its `fim_*` status flags. An optional watchdog aborts measurements whose echo never returns.

## Interface
- `TIMEOUT_CICLOS`, default 2_500_000: clock cycles allowed in AGUARDA_MEDIDA before abort (50 ms at 50 MHz).
- `clock` in 1: system clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low; asserts immediately, released synchronously by the flops.
- `ligar` in 1: level enable; sweep runs while high.
- `fim_distancia` in 1: measurement complete from the HC-SR04 interface.
- `fim_transmissao` in 1: tx_serial_7O1 pronto.
- `fim_contador_serial` in 1: serial char counter at 7.
- `fim_contador_intervalo` in 1: interval counter terminal count.
- `zera` out 1: synchronous clear of the datapath serial and interval counters.
- `zera_pwm` out 1: servo controller reset.
- `reset_updown` out 1: clears the servo position counter.
- `conta_intervalo` out 1: enables the interval counter.
- `medir` out 1: one-cycle measurement start.
- `transmitir` out 1: one-cycle tx start.
- `conta_serial` out 1: advances the char mux.
- `conta_updown` out 1: advances the servo position.
- `pronto` out 1: one-cycle pulse per completed position.
- `erro` out 1: sticky timeout flag.
- `db_estado` out 4: current state code.

## Operation
- Moore FSM, one 4-bit state register; all control outputs decode from state only.
- States, with codes and outputs:
  - INICIAL 0x0: all outputs 0.
  - PREPARACAO 0x1: `zera`, `zera_pwm` and `reset_updown` = 1.
  - ESPERA 0x2: `conta_intervalo` = 1.
  - MEDIR 0x3: `medir` = 1.
  - AGUARDA_MEDIDA 0x4: no outputs.
  - TRANSMITE 0x5: `transmitir` = 1.
  - AGUARDA_TX 0x6: no outputs.
  - PROX_CARACTERE 0x7: `conta_serial` = 1.
  - MOVE 0x8: `conta_updown` and `pronto` = 1.
  - FALHA 0xE: no outputs.
- Transitions:
  - INICIAL → PREPARACAO when `ligar`=1.
  - PREPARACAO → ESPERA, unconditionally.
  - ESPERA → INICIAL if `ligar`=0 (checked first); else → MEDIR on `fim_contador_intervalo`.
  - MEDIR → AGUARDA_MEDIDA.
  - AGUARDA_MEDIDA → TRANSMITE on `fim_distancia`; → FALHA on timeout.
  - TRANSMITE → AGUARDA_TX.
  - AGUARDA_TX → PROX_CARACTERE on `fim_transmissao`.
  - PROX_CARACTERE → MOVE if `fim_contador_serial`=1 (last char sent; the counter wraps to 0 on the same edge); else → TRANSMITE.
  - MOVE → ESPERA.
  - FALHA → MOVE, so the servo still advances and no frame is sent.
- `ligar` is examined only in INICIAL and ESPERA. A frame in progress always completes.
- `erro`:
  - set on entry to FALHA;
  - cleared in PREPARACAO and on reset;
  - otherwise holds.
- Unused codes (0x9–0xD, 0xF) → INICIAL on the next edge.

## Timing
- Reset values: state INICIAL, every output 0, `db_estado`=0x0, timeout counter 0.
- `reset` low mid-operation: state returns to INICIAL within the same cycle (asynchronous). Datapath handshakes in flight are abandoned.
- `medir`, `transmitir`, `conta_serial`, `conta_updown` and `pronto` are exactly one cycle wide per visit.
- Status latency: a status input high at edge N moves the state at edge N; the new outputs are valid after edge N.
- Minimum per-character loop with status already high: 3 cycles (TRANSMITE, AGUARDA_TX, PROX_CARACTERE).
- Timeout counter:
  - width $clog2(TIMEOUT_CICLOS+1);
  - clears in MEDIR, increments each cycle in AGUARDA_MEDIDA, saturates;
  - timeout = (count == TIMEOUT_CICLOS-1) while in AGUARDA_MEDIDA.
- `fim_distancia` and timeout in the same cycle: `fim_distancia` wins (→ TRANSMITE, `erro` unchanged).

## Configuration
- `SONAR_UC_TIMEOUT_EN` defined: watchdog counter and FALHA state are compiled in, as specified above.
- Not defined:
  - no counter is synthesized;
  - AGUARDA_MEDIDA waits indefinitely for `fim_distancia`;
  - FALHA is unreachable (its code decodes to INICIAL);
  - `erro` is tied to 0.

## Test plan
- Reset, then `ligar`=1 → PREPARACAO, ESPERA on successive edges. `zera`, `zera_pwm` and `reset_updown` are high for exactly 1 cycle.
- `fim_contador_intervalo` pulse, then `fim_distancia` after 20 cycles → `medir` high for 1 cycle; TRANSMITE entered 1 cycle after `fim_distancia`.
- Datapath model asserts `fim_contador_serial` on the 8th char → exactly 8 `transmitir` and 8 `conta_serial` pulses, then 1 `conta_updown`/`pronto` pulse, then state 0x2.
- With the macro and TIMEOUT_CICLOS=16, `fim_distancia` never asserted → FALHA after 16 cycles in 0x4, `erro`=1, `conta_updown` pulse, no `transmitir`. `erro` clears on the next PREPARACAO.
- `ligar` dropped during AGUARDA_TX → frame completes (8 chars), MOVE, then ESPERA → INICIAL. Outputs all 0.
- `reset` asserted low in state 0x6 → `db_estado`=0x0 and all outputs 0 before the next clock edge.
